board_reader: RTL

//  Read side of the 32x24 tile board RAM. The board writer fills this RAM with 4-bit tile codes.

---
 rtl/board_pkg.sv | 22 ++
 rtl/board_reader_tile_scan_counter.sv | 52 +++++
 rtl/board_reader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the tile board RAM: geometry and tile codes.
// Used by both the board writer and the board reader.
package board_pkg;

   localparam int BOARD_COLS  = 32;
   localparam int BOARD_ROWS  = 24;
   localparam int TILE_PX     = 20;
   localparam int BOARD_CELLS = BOARD_COLS * BOARD_ROWS;

   typedef enum logic [3:0] {
      TILE_EMPTY  = 4'h0,
      TILE_WALL   = 4'h1,
      TILE_PELLET = 4'h2,
      TILE_POWER  = 4'h3,
      TILE_GATE   = 4'h4
   } tile_t;

   function automatic logic is_pellet(input logic [3:0] code);
      return (code == TILE_PELLET) || (code == TILE_POWER);
   endfunction

endpackage

// File: rtl/board_reader_tile_scan_counter.sv
// Raster position in tile coordinates: four nested counters (pixel within tile, tile column,
// pixel row within tile, tile row). frame_start wins over px_adv in the same cycle.
module tile_scan_counter
   import board_pkg::*;
#(
   parameter int PX_PER_TILE = TILE_PX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       px_adv,
   output logic [4:0] tile_row,
   output logic [4:0] tile_col,
   output logic [4:0] row_pix,
   output logic [4:0] col_pix,
   output logic       last_px
);

   localparam logic [4:0] PIX_LAST = 5'(PX_PER_TILE - 1);
   localparam logic [4:0] COL_LAST = 5'(BOARD_COLS - 1);
   localparam logic [4:0] ROW_LAST = 5'(BOARD_ROWS - 1);

   logic col_end;
   logic line_end;
   logic row_end;

   assign col_end  = (col_pix == PIX_LAST);
   assign line_end = col_end && (tile_col == COL_LAST);
   assign row_end  = (row_pix == PIX_LAST);
   assign last_px  = line_end && row_end && (tile_row == ROW_LAST);

   always_ff @(posedge clk) begin
      if (reset || frame_start) begin
         col_pix  <= '0;
         tile_col <= '0;
         row_pix  <= '0;
         tile_row <= '0;
      end else if (px_adv) begin
         col_pix <= col_end ? 5'd0 : col_pix + 5'd1;
         if (col_end) begin
            tile_col <= line_end ? 5'd0 : tile_col + 5'd1;
         end
         if (line_end) begin
            row_pix <= row_end ? 5'd0 : row_pix + 5'd1;
            if (row_end) begin
               tile_row <= (tile_row == ROW_LAST) ? 5'd0 : tile_row + 5'd1;
            end
         end
      end
   end

endmodule

// File: rtl/board_reader.sv
// Board RAM read side: raster-driven tile fetch with 2-cycle alignment of code and in-tile offset,
// plus a per-frame pellet count built only when BOARD_READER_PELLET_COUNT_EN is defined.
module board_reader
   import board_pkg::*;
#(
   parameter int PX_PER_TILE = TILE_PX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hold,
   input  logic       frame_start,
   input  logic       px_adv,
   output logic [9:0] rd_addr,
   input  logic [3:0] rd_data,
   output logic [3:0] tile_code,
   output logic [4:0] tile_px_x,
   output logic [4:0] tile_px_y,
   output logic       tile_valid,
   output logic [9:0] pellet_count,
   output logic       count_valid,
   output logic       board_clear
);

   logic [4:0] tile_row;
   logic [4:0] tile_col;
   logic [4:0] row_pix;
   logic [4:0] col_pix;
   logic       last_px;
   logic       fetch_v;

   tile_scan_counter #(
      .PX_PER_TILE (PX_PER_TILE)
   ) u_scan (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .px_adv      (px_adv),
      .tile_row    (tile_row),
      .tile_col    (tile_col),
      .row_pix     (row_pix),
      .col_pix     (col_pix),
      .last_px     (last_px)
   );

   assign rd_addr = {tile_row, tile_col};

   // A pixel presented together with frame_start belongs to the abandoned frame and is dropped.
   assign fetch_v = px_adv && !frame_start;

   logic       s1_valid;
   logic [4:0] s1_x;
   logic [4:0] s1_y;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
      end else begin
         s1_valid <= fetch_v;
         s1_x     <= col_pix;
         s1_y     <= row_pix;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tile_valid <= 1'b0;
         tile_px_x  <= '0;
         tile_px_y  <= '0;
         tile_code  <= TILE_EMPTY;
      end else begin
         tile_valid <= s1_valid;
         tile_px_x  <= s1_x;
         tile_px_y  <= s1_y;
         if (hold) begin
            tile_code <= TILE_EMPTY;
         end else if (s1_valid) begin
            tile_code <= rd_data;
         end
      end
   end

`ifdef BOARD_READER_PELLET_COUNT_EN
   logic       s1_origin;
   logic       wrap;
   logic       frame_ok;
   logic [9:0] acc;

   assign wrap = fetch_v && last_px;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_origin <= 1'b0;
      end else begin
         s1_origin <= (col_pix == 5'd0) && (row_pix == 5'd0);
      end
   end

   // Only tile-origin pixels are counted, so each tile contributes once per frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc          <= '0;
         frame_ok     <= 1'b1;
         pellet_count <= '0;
         count_valid  <= 1'b0;
      end else if (frame_start || wrap) begin
         acc      <= '0;
         frame_ok <= !hold;
         if (wrap && frame_ok && !hold) begin
            pellet_count <= acc;
            count_valid  <= 1'b1;
         end
      end else begin
         if (s1_valid && s1_origin && !hold && is_pellet(rd_data)) begin
            acc <= acc + 10'd1;
         end
         if (hold) begin
            frame_ok <= 1'b0;
         end
      end
   end

   assign board_clear = count_valid && (pellet_count == 10'd0);
`else
   logic unused_pellet_sigs;

   assign unused_pellet_sigs = last_px;
   assign pellet_count       = '0;
   assign count_valid        = 1'b0;
   assign board_clear        = 1'b0;
`endif

endmodule
